// File: rtl/dnn_batch_ctrl_pkg.sv
// Shared types and constants for the DNN batch controller slice.
package dnn_ctrl_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned DATA_WIDTH  = 2;
  localparam int unsigned ADDR_WIDTH  = 16;

  typedef logic signed [DATA_WIDTH-1:0]         score_t;
  typedef logic [NUM_CLASSES*DATA_WIDTH-1:0]    score_vec_t;

  typedef enum logic [3:0] {
    IDLE,
    ERST,
    ESTART,
    RUN,
    LBL,
    SCORE,
    EMIT,
    NEXT,
    FIN
  } ctrl_state_t;

  // Extract class i from the flat engine score bus (class 0 in the LSBs).
  function automatic score_t score_at(input score_vec_t v, input int unsigned i);
    return score_t'(v[i*DATA_WIDTH +: DATA_WIDTH]);
  endfunction

endpackage

// File: rtl/dnn_batch_ctrl_if.sv
// Engine, label-memory and result-stream signals between the controller and its environment.
interface dnn_batch_ctrl_if;
  import dnn_ctrl_pkg::*;

  logic                  dnn_reset;
  logic                  dnn_start;
  logic                  dnn_done;
  score_vec_t            dnn_out;
  logic [ADDR_WIDTH-1:0] dnn_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           lbl_addr;
  logic [3:0]            lbl_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [15:0]           res_index;
  logic [3:0]            res_digit;
  logic                  res_correct;

  modport master (
    output dnn_reset, dnn_start, mem_addr, lbl_addr,
           res_valid, res_index, res_digit, res_correct,
    input  dnn_done, dnn_out, dnn_addr, lbl_data, res_ready
  );

  modport slave (
    input  dnn_reset, dnn_start, mem_addr, lbl_addr,
           res_valid, res_index, res_digit, res_correct,
    output dnn_done, dnn_out, dnn_addr, lbl_data, res_ready
  );

endinterface

// File: rtl/dnn_batch_ctrl_argmax.sv
// Combinational argmax over the class scores; the lowest index wins a tie.
module dnn_argmax
  import dnn_ctrl_pkg::*;
(
  input  score_t     scores_i [NUM_CLASSES],
  output logic [3:0] idx_o
);

  score_t best;

  // Strictly-greater replacement keeps the earliest maximum on ties.
  always_comb begin
    best  = scores_i[0];
    idx_o = '0;
    for (int unsigned i = 1; i < NUM_CLASSES; i++) begin
      if (scores_i[i] > best) begin
        best  = scores_i[i];
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/dnn_batch_ctrl.sv
// Batch scheduler: sequences the inference engine over consecutive images,
// remaps activation reads into the current image window, scores each result
// against its label and streams the outcome.
module dnn_batch_ctrl
  import dnn_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0191,
  parameter logic [ADDR_WIDTH-1:0] ACT_BASE    = 16'h8000,
  parameter logic [ADDR_WIDTH-1:0] IMG_STRIDE  = 16'h0191,
  parameter logic [19:0]           TIMEOUT     = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic [15:0] num_images,
  output logic        busy,
  output logic        batch_done,
  output logic        timeout_err,
  output logic [15:0] correct_cnt,
  dnn_batch_ctrl_if.master bus
);

  ctrl_state_t           state_q, state_d;
  logic [15:0]           num_q, num_d;
  logic [15:0]           idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [19:0]           timer_q, timer_d;
  score_vec_t            scores_q, scores_d;
  logic [15:0]           lbl_addr_q, lbl_addr_d;
  logic [3:0]            digit_q, digit_d;
  logic                  correct_q, correct_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;

  score_t                scores [NUM_CLASSES];
  logic [3:0]            argmax_idx;

  // Unpack the scores latched on dnn_done for the argmax.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      scores[i] = score_at(scores_q, i);
    end
  end

  dnn_argmax u_argmax (
    .scores_i (scores),
    .idx_o    (argmax_idx)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      timer_q    <= '0;
      scores_q   <= '0;
      lbl_addr_q <= '0;
      digit_q    <= '0;
      correct_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      timer_q    <= timer_d;
      scores_q   <= scores_d;
      lbl_addr_q <= lbl_addr_d;
      digit_q    <= digit_d;
      correct_q  <= correct_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update for the batch sequence.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    base_d     = base_q;
    timer_d    = timer_q;
    scores_d   = scores_q;
    lbl_addr_d = lbl_addr_q;
    digit_d    = digit_q;
    correct_d  = correct_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    // Abort outranks done and timeout. FIN itself always falls back to IDLE so a
    // held abort level cannot trap the FSM in FIN re-emitting batch_done.
    if (cmd_abort && state_q != IDLE && state_q != FIN) begin
      state_d = FIN;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_start) begin
            cnt_d   = '0;
            err_d   = 1'b0;
            num_d   = num_images;
            idx_d   = '0;
            base_d  = '0;
            state_d = (num_images == 16'd0) ? FIN : ERST;
          end
        end
        ERST:   state_d = ESTART;
        ESTART: begin
          timer_d = '0;
          state_d = RUN;
        end
        RUN: begin
          if (bus.dnn_done) begin
            scores_d   = bus.dnn_out;
            lbl_addr_d = idx_q;
            state_d    = LBL;
          end else begin
            timer_d = timer_q + 20'd1;
            if (timer_q + 20'd1 == TIMEOUT) begin
              err_d   = 1'b1;
              state_d = FIN;
            end
          end
        end
        LBL:    state_d = SCORE;
        SCORE: begin
          digit_d   = argmax_idx;
          correct_d = (argmax_idx == bus.lbl_data);
          if (argmax_idx == bus.lbl_data && cnt_q != '1) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = EMIT;
        end
        EMIT: begin
          if (bus.res_ready) state_d = NEXT;
        end
        NEXT: begin
          if (idx_q == num_q - 16'd1) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 16'd1;
            base_d  = base_q + IMG_STRIDE;
            state_d = ERST;
          end
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign batch_done  = (state_q == FIN);
  assign timeout_err = err_q;
  assign correct_cnt = cnt_q;

  assign bus.dnn_reset   = (state_q == ERST) || (state_q == FIN);
  assign bus.dnn_start   = (state_q == ESTART);
  assign bus.lbl_addr    = lbl_addr_q;
  assign bus.res_valid   = (state_q == EMIT);
  assign bus.res_index   = idx_q;
  assign bus.res_digit   = digit_q;
  assign bus.res_correct = correct_q;

  // Activation reads land in the current image window; weight space passes through.
  assign bus.mem_addr = (bus.dnn_addr < ADDR_BASE_W) ? (ACT_BASE + base_q + bus.dnn_addr)
                                                     : bus.dnn_addr;

endmodule
